// File: rtl/pipe_generator.sv
// pipe_generator: paces pipe wall patterns into the rightmost column, gap rows chosen by an LFSR.
module pipe_generator #(
  parameter int TICK_DIV = 2560,
  parameter int SPACING = 4,
  parameter int PIPE_WIDTH = 1,
  parameter int GAP = 3,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       lossDetect,
  output logic [7:0] rightCol,
  output logic       newPipe,
  output logic [7:0] pipeCount
);
  typedef enum logic [1:0] {IDLE, SPACE, PIPE} state_t;
  localparam logic [11:0] TICK_LAST = 12'(TICK_DIV - 1);
  localparam logic [15:0] SPACE_LAST = 16'(SPACING - 1);
  localparam logic [15:0] PIPE_LAST = 16'(PIPE_WIDTH - 1);
  localparam logic [2:0] GAP_MAX = 3'(8 - GAP);
  localparam logic [2:0] GAP_WRAP = 3'(9 - GAP);
  localparam logic [7:0] GAP_MASK = 8'((1 << GAP) - 1);
  state_t state;
  logic [11:0] tick_cnt;
  logic [15:0] col_cnt;
  logic [7:0] lfsr;
  logic [2:0] gap_pos;
  logic [7:0] pattern;
  logic tick;
  assign tick = tick_cnt == TICK_LAST;
  // LFSR values past the last legal gap position fold back to the bottom rows
  assign gap_pos = lfsr[2:0] <= GAP_MAX ? lfsr[2:0] : lfsr[2:0] - GAP_WRAP;
  assign pattern = ~(GAP_MASK << gap_pos);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rightCol <= '0;
      newPipe <= 1'b0;
      pipeCount <= '0;
      tick_cnt <= '0;
      col_cnt <= '0;
      lfsr <= SEED;
    end else if (lossDetect) begin
      state <= IDLE;
      rightCol <= '0;
      newPipe <= 1'b0;
      pipeCount <= '0;
      tick_cnt <= '0;
      col_cnt <= '0;
    end else begin
      newPipe <= 1'b0;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          col_cnt <= '0;
          rightCol <= '0;
          if (start) state <= SPACE;
        end
        SPACE: begin
          tick_cnt <= tick ? 12'd0 : tick_cnt + 12'd1;
          if (tick) begin
            if (col_cnt == SPACE_LAST) begin
              state <= PIPE;
              col_cnt <= '0;
              rightCol <= pattern;
              newPipe <= 1'b1;
              pipeCount <= pipeCount + 8'd1;
            end else begin
              col_cnt <= col_cnt + 16'd1;
              rightCol <= '0;
            end
          end
        end
        PIPE: begin
          tick_cnt <= tick ? 12'd0 : tick_cnt + 12'd1;
          if (tick) begin
            if (col_cnt == PIPE_LAST) begin
              state <= SPACE;
              col_cnt <= '0;
              rightCol <= '0;
              lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end else begin
              col_cnt <= col_cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_generator.sv
// tb_pipe_generator: random and directed stimulus checked against an arithmetic model of pipe timing.
module tb_pipe_generator;
  localparam int TD = 4, SP = 2, PW = 1, GP = 3;
  localparam logic [7:0] SD = 8'hA5;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, lossDetect = 1'b0;
  logic [7:0] rightCol, pipeCount;
  logic newPipe;
  int n_cmp = 0, n_bad = 0;
  bit m_active = 1'b0;
  int m_k = 0;
  logic [7:0] m_base = SD;
  logic prev_np = 1'b0;
  pipe_generator #(.TICK_DIV(TD), .SPACING(SP), .PIPE_WIDTH(PW), .GAP(GP), .SEED(SD)) dut (
    .clock(clock), .reset(reset), .start(start), .lossDetect(lossDetect),
    .rightCol(rightCol), .newPipe(newPipe), .pipeCount(pipeCount)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] lfsr_adv(input logic [7:0] l, input int n);
    for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction
  function automatic logic [7:0] pat(input logic [7:0] l);
    int g;
    logic [7:0] p;
    g = int'(l[2:0]);
    if (g > 8 - GP) g -= 9 - GP;
    for (int i = 0; i < 8; i++) p[i] = !(i >= g && i < g + GP);
    return p;
  endfunction
  // k = edges since the start edge; t = ticks elapsed; each pipe period is SP+PW ticks
  task automatic compare_model();
    int t, per;
    logic [7:0] e_rc, e_pc;
    logic e_np;
    per = SP + PW;
    t = m_k / TD;
    e_rc = (m_active && t > 0 && t % per >= SP) ? pat(lfsr_adv(m_base, t / per)) : 8'h00;
    e_np = m_active && t > 0 && m_k % TD == 0 && t % per == SP;
    e_pc = m_active ? 8'(((t + PW) / per) % 256) : 8'h00;
    check("rightCol", rightCol, e_rc);
    check("newPipe", newPipe, e_np);
    check("pipeCount", pipeCount, e_pc);
    check("np_twice", prev_np & newPipe, 0);
    prev_np = newPipe;
  endtask
  task automatic model_step(input logic s, input logic l);
    if (l) begin
      if (m_active) m_base = lfsr_adv(m_base, (m_k / TD) / (SP + PW));
      m_active = 1'b0;
      m_k = 0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1'b1;
        m_k = 0;
      end
    end else m_k++;
  endtask
  task automatic model_reset();
    m_active = 1'b0;
    m_k = 0;
    m_base = SD;
    prev_np = 1'b0;
  endtask
  task automatic cycle(input logic s, input logic l);
    @(negedge clock);
    start = s;
    lossDetect = l;
    @(posedge clock);
    model_step(s, l);
    #1;
    compare_model();
  endtask
  initial begin
    int pulses;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    #1;
    check("reset_rc", rightCol, 8'h00);
    check("reset_np", newPipe, 1'b0);
    check("reset_pc", pipeCount, 8'h00);
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'($urandom_range(0, 1)), 1'b0);
    check("e8_rc", rightCol, 8'h1F);
    check("e8_np", newPipe, 1'b1);
    check("e8_pc", pipeCount, 8'd1);
    cycle(1'b0, 1'b0);
    check("e9_np", newPipe, 1'b0);
    repeat (11) cycle(1'($urandom_range(0, 1)), 1'b0);
    check("e20_rc", rightCol, 8'hE3);
    check("e20_pc", pipeCount, 8'd2);
    cycle(1'b0, 1'b1);
    check("loss_rc", rightCol, 8'h00);
    check("loss_pc", pipeCount, 8'h00);
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    check("restart_rc", rightCol, 8'hE3);
    cycle(1'b1, 1'b1);
    check("both_rc", rightCol, 8'h00);
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    check("both_then_start_rc", rightCol, 8'hE3);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    check("pre_async_rc", rightCol, 8'h1F);
    #2;
    reset = 1'b1;
    #1;
    check("async_rc", rightCol, 8'h00);
    check("async_np", newPipe, 1'b0);
    check("async_pc", pipeCount, 8'h00);
    model_reset();
    #1;
    reset = 1'b0;
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    check("post_async_rc", rightCol, 8'h1F);
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 79) == 0));
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 256 * (SP + PW) * TD + 40 && pulses < 256; i++) begin
      cycle(1'b0, 1'b0);
      if (newPipe) begin
        pulses++;
        if (pulses == 256) check("wrap_pc", pipeCount, 8'h00);
      end
    end
    check("wrap_pulses", pulses, 256);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
